// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, idle-high line, with a
// one-byte holding register so a byte arriving mid-frame is not lost.
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   data_valid one-cycle strobe, data is a byte to send
//   data       byte to transmit
//   uart_txd   serial line, 1 = idle/mark
//   tx_busy    frame in flight or holding register full
//   tx_done    one-cycle pulse in the last cycle of each stop bit
//   overrun    one-cycle pulse when an incoming byte is dropped
module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_valid,
    input  logic [7:0] data,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       overrun
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;

    logic baud_last;
    logic stop_last;
    logic direct_load;

    assign baud_last = (baud_q == BAUD_MAX);
    assign stop_last = (state_q == STOP) && baud_last;
    // A byte arriving in the final stop cycle with hold empty goes straight
    // into the shifter so it never lands in hold while the FSM idles.
    assign direct_load = stop_last && !hold_full_q && data_valid;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q + BW'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovr_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (data_valid) begin
                    shift_d = data;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = START;
                    end else if (data_valid) begin
                        shift_d = data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        // Hold capture; in the final stop cycle the hold slot is vacated
        // the same cycle, so a full hold can still accept the new byte.
        if (data_valid && (state_q != IDLE) && !direct_load) begin
            if (!hold_full_q || stop_last) begin
                hold_d      = data;
                hold_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        unique case (state_d)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[idx_d];
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE) || hold_full_d;
        done_d = (state_d == STOP) && (baud_d == BAUD_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at 4 and 217 clocks per bit,
// with a mid-bit sampling receiver recovering each transmitted byte.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       dv1, dv2;
    logic [7:0] d1, d2;
    logic       txd1, busy1, done1, ovr1;
    logic       txd2, busy2, done2, ovr2;

    int errors = 0;
    int checks = 0;
    int last_ovn;
    int last_ova;

    uart_tx #(.CLKS_PER_BIT(4)) u1 (
        .clk(clk), .rst_n(rst_n), .data_valid(dv1), .data(d1),
        .uart_txd(txd1), .tx_busy(busy1), .tx_done(done1),
        .overrun(ovr1)
    );

    uart_tx #(.CLKS_PER_BIT(217)) u2 (
        .clk(clk), .rst_n(rst_n), .data_valid(dv2), .data(d2),
        .uart_txd(txd2), .tx_busy(busy2), .tx_done(done2),
        .overrun(ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] b);
        if (sel) begin
            dv2 = v;
            d2  = b;
        end else begin
            dv1 = v;
            d1  = b;
        end
    endtask

    // Strobe one byte; returns at the sample point of the first low cycle.
    task automatic send(input bit sel, input logic [7:0] b);
        drive(sel, 1'b1, b);
        tick();
        drive(sel, 1'b0, 8'h00);
    endtask

    // Called at the first low cycle of a frame; walks the full frame,
    // optionally strobing bytes at cycles ia/ja of the frame.
    task automatic expect_frame(input bit sel, input int cpb,
                                input logic [7:0] b,
                                input int ia, input logic [7:0] ib,
                                input int ja, input logic [7:0] jb,
                                input string tag);
        logic [9:0] fr;
        logic [7:0] rx;
        logic       t, d, bz, ov;
        int         bad;
        fr = {1'b1, b, 1'b0};
        rx = 8'h00;
        bad = 0;
        last_ovn = 0;
        last_ova = -1;
        for (int i = 0; i < 10 * cpb; i++) begin
            t  = sel ? txd2 : txd1;
            d  = sel ? done2 : done1;
            bz = sel ? busy2 : busy1;
            ov = sel ? ovr2 : ovr1;
            if (t !== fr[i / cpb]) bad++;
            if (d !== (i == 10 * cpb - 1)) bad++;
            if (bz !== 1'b1) bad++;
            if (ov === 1'b1) begin
                last_ovn++;
                last_ova = i;
            end
            if ((i % cpb) == cpb / 2 && i / cpb >= 1 && i / cpb <= 8)
                rx[i / cpb - 1] = t;
            if (i == ia) drive(sel, 1'b1, ib);
            else if (i == ja) drive(sel, 1'b1, jb);
            else drive(sel, 1'b0, 8'h00);
            tick();
        end
        check({tag, "_wave"}, bad, 0);
        check({tag, "_rx"}, {24'd0, rx}, {24'd0, b});
    endtask

    int lowcnt;
    int donecnt;

    initial begin
        rst_n = 1'b0;
        dv1 = 1'b0; d1 = 8'h00;
        dv2 = 1'b0; d2 = 8'h00;
        tick();
        tick();
        check("rst_txd", txd1, 1);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_ovr", ovr1, 0);
        check("rst_txd217", txd2, 1);
        rst_n = 1'b1;
        tick();
        check("idle_txd", txd1, 1);

        // 1: single A5 frame, exact waveform and tx_done position
        send(1'b0, 8'hA5);
        check("s1_start_low", txd1, 0);
        check("s1_busy_rise", busy1, 1);
        expect_frame(1'b0, 4, 8'hA5, -1, 8'h00, -1, 8'h00, "s1");
        check("s1_busy_fall", busy1, 0);
        check("s1_idle_high", txd1, 1);

        // 2: all-zero then all-one data
        send(1'b0, 8'h00);
        expect_frame(1'b0, 4, 8'h00, -1, 8'h00, -1, 8'h00, "s2a");
        send(1'b0, 8'hFF);
        expect_frame(1'b0, 4, 8'hFF, -1, 8'h00, -1, 8'h00, "s2b");
        check("s2_busy_fall", busy1, 0);

        // 3: second byte held, sent with no idle gap
        send(1'b0, 8'h31);
        expect_frame(1'b0, 4, 8'h31, 10, 8'h32, -1, 8'h00, "s3a");
        check("s3a_ovr", last_ovn, 0);
        expect_frame(1'b0, 4, 8'h32, -1, 8'h00, -1, 8'h00, "s3b");
        check("s3b_ovr", last_ovn, 0);
        check("s3_busy_fall", busy1, 0);

        // 4: third byte in one frame is dropped with one overrun
        send(1'b0, 8'h11);
        expect_frame(1'b0, 4, 8'h11, 10, 8'h22, 20, 8'h33, "s4a");
        check("s4_ovr_cnt", last_ovn, 1);
        check("s4_ovr_at", last_ova, 21);
        expect_frame(1'b0, 4, 8'h22, -1, 8'h00, -1, 8'h00, "s4b");
        lowcnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (txd1 !== 1'b1) lowcnt++;
            tick();
        end
        check("s4_no_third", lowcnt, 0);
        check("s4_busy_fall", busy1, 0);

        // 5: reset during data bit 3 with hold full
        send(1'b0, 8'h44);
        for (int c = 0; c < 17; c++) begin
            if (c == 2) drive(1'b0, 1'b1, 8'h55);
            else drive(1'b0, 1'b0, 8'h00);
            tick();
        end
        check("s5_busy_pre", busy1, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s5_txd_rst", txd1, 1);
        check("s5_busy_rst", busy1, 0);
        check("s5_done_rst", done1, 0);
        lowcnt = 0;
        donecnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (txd1 !== 1'b1) lowcnt++;
            if (done1 !== 1'b0) donecnt++;
            tick();
        end
        check("s5_quiet_line", lowcnt, 0);
        check("s5_no_done", donecnt, 0);
        send(1'b0, 8'h5A);
        expect_frame(1'b0, 4, 8'h5A, -1, 8'h00, -1, 8'h00, "s5");
        check("s5_busy_fall", busy1, 0);

        // 6: strobe in final stop cycle while hold full
        send(1'b0, 8'h66);
        expect_frame(1'b0, 4, 8'h66, 5, 8'h77, 39, 8'h88, "s6a");
        check("s6a_ovr", last_ovn, 0);
        expect_frame(1'b0, 4, 8'h77, -1, 8'h00, -1, 8'h00, "s6b");
        check("s6b_ovr", last_ovn, 0);
        expect_frame(1'b0, 4, 8'h88, -1, 8'h00, -1, 8'h00, "s6c");
        check("s6c_ovr", last_ovn, 0);
        check("s6_busy_fall", busy1, 0);

        // 6b: A5 at 217 clocks per bit
        send(1'b1, 8'hA5);
        check("s7_start_low", txd2, 0);
        expect_frame(1'b1, 217, 8'hA5, -1, 8'h00, -1, 8'h00, "s7");
        check("s7_busy_fall", busy2, 0);
        check("s7_idle_high", txd2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1, LSB first, idle-high line. Sits directly downstream of uart_rx in the receiver top. It consumes the uart_rx data_valid/data byte stream and echoes each byte back to the host on the TX pin. A one-entry holding register absorbs a byte that arrives mid-frame, so back-to-back echo traffic is not lost.

Parameters:
CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200 baud); legal range 2..65535.

Ports:
clk  input  1  system clock (FPGA_CLK at top level)
rst_n  input  1  synchronous reset, active-low
data_valid  input  1  one-cycle strobe: data is a byte to send
data  input  8  byte to transmit, sampled when data_valid=1
uart_txd  output  1  serial line; 1 = idle/mark
tx_busy  output  1  high while a frame is in flight or the holding register is full
tx_done  output  1  one-cycle pulse in the last cycle of each stop bit
overrun  output  1  one-cycle pulse when an incoming byte is dropped

Behaviour:
- Reset: the clock is the only clock; reset is synchronous, active-low, sampled on the rising clk edge.
- Reset values: uart_txd=1, tx_busy=0, tx_done=0, overrun=0, state=IDLE, hold empty, bit counter=0, baud counter=0.
- Reset mid-frame aborts the frame immediately. The line returns high on the next edge and the holding register is cleared.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - uart_txd=1.
  - data_valid=1 in cycle N: latch data into the shift register and enter START.
  - uart_txd=0 from cycle N+1.
  - tx_busy=1 from N+1.
- START: drive 0 for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
- DATA:
  - Drive shift[idx] for CLKS_PER_BIT cycles per bit, idx 0..7, LSB first.
  - After idx 7 completes, enter STOP.
- STOP:
  - Drive 1 for CLKS_PER_BIT cycles.
  - tx_done=1 in the final STOP cycle only.
  - Leaving STOP:
    - hold full: load hold into the shift register, clear hold, enter START. No idle cycle between the stop bit and the next start bit.
    - hold empty: enter IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles, from the first low cycle to the cycle after tx_done.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Width = clog2(CLKS_PER_BIT).
  - Reset to 0 on every state entry.
- Holding register, applies when data_valid=1 while state != IDLE:
  - hold empty: capture data, hold becomes full.
  - hold full: byte dropped, overrun=1 for that cycle, hold unchanged.
  - Simultaneous event: data_valid=1 in the final STOP cycle while hold is full. The hold byte is loaded into the shift register that cycle, and the incoming byte is captured into hold in the same cycle. No overrun.
- tx_busy = (state != IDLE) OR hold full; it is registered.
- tx_busy falls on the same edge the state returns to IDLE.
- data is ignored whenever data_valid=0. data_valid=1 in IDLE with hold empty never raises overrun.
- All outputs are registered. No combinational path exists from inputs to outputs.

Test Plan:
1. CLKS_PER_BIT=4; reset, then data_valid pulse with data=8'hA5 -> uart_txd sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. tx_done pulses once, 40 cycles after the first low cycle minus 1. tx_busy falls the next cycle.
2. Send 8'h00, then 8'hFF -> all-low data bits, then all-high data bits. The stop bit is always 1. A loopback uart_rx model recovers 8'h00 and 8'hFF.
3. Send 8'h31, then 8'h32 at cycle 10 of the first frame -> the second frame's start bit begins the cycle after the first tx_done, with no idle gap. Both bytes are received in order. overrun stays 0.
4. Send 8'h11, then 8'h22 and 8'h33 during the first frame -> overrun pulses exactly once, on the 8'h33 strobe. Only 8'h11 and 8'h22 are transmitted.
5. Assert rst_n=0 for 1 cycle during DATA bit 3 with hold full -> uart_txd=1 on the next edge; tx_busy=0; no tx_done. A new byte 8'h5A afterwards transmits cleanly.
6. Hold full, with data_valid coinciding with the final STOP cycle -> hold byte and new byte are transmitted back-to-back. overrun=0. Also repeat scenario 1 with CLKS_PER_BIT=217 to check the bit period.
